cmd_dispatcher: RTL and testbench

CMD_DISPATCHER -- requirements
Module: cmd_dispatcher

---
 rtl/cmd_dispatcher.sv | 192 +++++++++++++++++++
 tb/tb_cmd_dispatcher.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_dispatcher.sv
// Command dispatcher: queues {cmd, arg0} commands and runs them one at a time on indexed agents.
// Optional busy-cycle counter port is enabled with `define CMD_DISPATCHER_PERF_EN.
module cmd_dispatcher #(
  parameter int NUM_AGENTS = 4,
  parameter int SEL_WIDTH  = 2,
  parameter int ROW_WIDTH  = 8,
  parameter int COLS_WIDTH = 10,
  parameter int RES_WIDTH  = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [2:0]                       cmd,
  input  logic [31:0]                      cmd_arg0,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  output logic [RES_WIDTH-1:0]             res,
  output logic                             res_valid,
  input  logic                             res_ready,
  output logic                             cmd_error,
  output logic [NUM_AGENTS-1:0]            agent_start,
  input  logic [NUM_AGENTS-1:0]            agent_ready,
  output logic [31:0]                      agent_arg0,
  input  logic [NUM_AGENTS*RES_WIDTH-1:0]  agent_res,
  input  logic [NUM_AGENTS*ROW_WIDTH-1:0]  agent_row_select,
  input  logic [NUM_AGENTS*COLS_WIDTH-1:0] agent_columns_new,
  input  logic [NUM_AGENTS-1:0]            agent_columns_write,
  output logic [ROW_WIDTH-1:0]             arena_row_select,
  output logic [COLS_WIDTH-1:0]            arena_columns_new,
  output logic                             arena_columns_write,
  output logic [2:0]                       state_dbg
`ifdef CMD_DISPATCHER_PERF_EN
  ,
  output logic [31:0]                      perf_busy_cycles
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    SETTLE = 3'd2,
    WAIT   = 3'd3,
    RESULT = 3'd4
  } state_t;

  state_t state_q, state_d;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid and its payload stay stable until that edge, ready may change freely.
  logic [34:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             push, pop, fifo_empty, fifo_full;
  logic [2:0]       head_cmd;
  logic [31:0]      head_arg;
  logic             head_bad;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign cmd_ready  = !fifo_full;
  assign push       = cmd_valid && !fifo_full;
  assign head_cmd   = mem[rd_ptr][34:32];
  assign head_arg   = mem[rd_ptr][31:0];
  assign head_bad   = ({29'd0, head_cmd} >= 32'(NUM_AGENTS));

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd, cmd_arg0};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  logic [SEL_WIDTH-1:0]  idx_q;
  logic [31:0]           arg0_q;
  logic [RES_WIDTH-1:0]  res_q;
  logic                  load, capture;
  logic                  sel_ready, sel_wr;
  logic [RES_WIDTH-1:0]  sel_res;
  logic [ROW_WIDTH-1:0]  sel_row;
  logic [COLS_WIDTH-1:0] sel_cols;

  always_comb begin
    sel_ready = 1'b0;
    sel_wr    = 1'b0;
    sel_res   = '0;
    sel_row   = '0;
    sel_cols  = '0;
    for (int i = 0; i < NUM_AGENTS; i++) begin
      if (idx_q == SEL_WIDTH'(i)) begin
        sel_ready = agent_ready[i];
        sel_wr    = agent_columns_write[i];
        sel_res   = agent_res[i*RES_WIDTH +: RES_WIDTH];
        sel_row   = agent_row_select[i*ROW_WIDTH +: ROW_WIDTH];
        sel_cols  = agent_columns_new[i*COLS_WIDTH +: COLS_WIDTH];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    load      = 1'b0;
    capture   = 1'b0;
    cmd_error = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (head_bad) begin
            cmd_error = 1'b1;
          end else begin
            load    = 1'b1;
            state_d = START;
          end
        end
      end
      START:  state_d = SETTLE;
      // One settle cycle so the agent has dropped ready before we look at it.
      SETTLE: state_d = WAIT;
      WAIT: begin
        if (sel_ready) begin
          capture = 1'b1;
          state_d = RESULT;
        end
      end
      RESULT: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      arg0_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        idx_q  <= SEL_WIDTH'(head_cmd);
        arg0_q <= head_arg;
      end
      if (capture) res_q <= sel_res;
    end
  end

  always_comb begin
    agent_start = '0;
    for (int i = 0; i < NUM_AGENTS; i++) begin
      agent_start[i] = (state_q == START) && (idx_q == SEL_WIDTH'(i));
    end
  end

  logic arena_active;
  assign arena_active        = (state_q == START) || (state_q == SETTLE) || (state_q == WAIT);
  assign arena_row_select    = arena_active ? sel_row  : '0;
  assign arena_columns_new   = arena_active ? sel_cols : '0;
  assign arena_columns_write = arena_active && sel_wr;

  assign agent_arg0 = arg0_q;
  assign res        = res_q;
  assign res_valid  = (state_q == RESULT);
  assign state_dbg  = state_q;

`ifdef CMD_DISPATCHER_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_busy_cycles <= '0;
    end else if ((state_q != IDLE) && (perf_busy_cycles != 32'hFFFF_FFFF)) begin
      perf_busy_cycles <= perf_busy_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cmd_dispatcher.sv
// Directed bench for cmd_dispatcher: agent models, result scoreboard and boundary checks.
// Covers the busy-cycle counter too when CMD_DISPATCHER_PERF_EN is defined.
module tb_cmd_dispatcher;
  localparam int NA = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  cmd = '0;
  logic [31:0] cmd_arg0 = '0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] res;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic        cmd_error;
  logic [NA-1:0]    agent_start;
  logic [NA-1:0]    agent_ready = '1;
  logic [31:0]      agent_arg0;
  logic [NA*32-1:0] agent_res = '0;
  logic [NA*8-1:0]  agent_row_select = '0;
  logic [NA*10-1:0] agent_columns_new = '0;
  logic [NA-1:0]    agent_columns_write = '0;
  logic [7:0]  arena_row_select;
  logic [9:0]  arena_columns_new;
  logic        arena_columns_write;
  logic [2:0]  state_dbg;
`ifdef CMD_DISPATCHER_PERF_EN
  logic [31:0] perf;
`endif

  cmd_dispatcher dut (
    .clk(clk), .reset(reset),
    .cmd(cmd), .cmd_arg0(cmd_arg0), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .res(res), .res_valid(res_valid), .res_ready(res_ready), .cmd_error(cmd_error),
    .agent_start(agent_start), .agent_ready(agent_ready), .agent_arg0(agent_arg0),
    .agent_res(agent_res), .agent_row_select(agent_row_select),
    .agent_columns_new(agent_columns_new), .agent_columns_write(agent_columns_write),
    .arena_row_select(arena_row_select), .arena_columns_new(arena_columns_new),
    .arena_columns_write(arena_columns_write), .state_dbg(state_dbg)
`ifdef CMD_DISPATCHER_PERF_EN
    , .perf_busy_cycles(perf)
`endif
  );

  // clock / global time limit
  always #5 clk = ~clk;
  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "time limit");
  end

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  int exp_starts = 0, start_cnt = 0;
  int exp_results = 0, res_cnt = 0;
  int err_pulses = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] agent_fn(input int i, input logic [31:0] a);
    logic [31:0] k;
    k = 32'h0101_0101 * 32'(i + 1);
    return a ^ k;
  endfunction

  // agent models: drop ready on start, hold junk while busy, then present f(i, arg0)
  int          busy_len[NA] = '{default: 0};
  int          cnt[NA]      = '{default: 0};
  logic [31:0] arg_l[NA];
  always @(negedge clk) begin
    for (int i = 0; i < NA; i++) begin
      if (agent_start[i]) begin
        agent_ready[i] = 1'b0;
        cnt[i] = busy_len[i];
        arg_l[i] = agent_arg0;
        agent_res[i*32 +: 32] = 32'hBAD0_0000 | 32'(i);
      end else if (!agent_ready[i]) begin
        if (cnt[i] == 0) begin
          agent_ready[i] = 1'b1;
          agent_res[i*32 +: 32] = agent_fn(i, arg_l[i]);
        end else begin
          cnt[i]--;
        end
      end
    end
  end

  // scoreboard: a result transfers on the edge following a negedge with valid && ready
  always @(negedge clk) begin
    if (!reset) begin
      if (res_valid && res_ready) begin
        res_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL unexpected_result: observed=%0h expected=none", res);
        end else begin
          check("result", res, exp_q.pop_front());
        end
      end
      if (cmd_error) err_pulses++;
      if (agent_start != '0) begin
        start_cnt++;
        check("start_onehot", $countones(agent_start), 1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] c, input logic [31:0] a);
    logic acc;
    acc = 1'b0;
    cmd = c;
    cmd_arg0 = a;
    cmd_valid = 1'b1;
    for (int n = 0; n < 300 && !acc; n++) begin
      @(negedge clk);
      acc = cmd_ready;
      tick();
    end
    cmd_valid = 1'b0;
    check("send_accept", acc, 1);
    if (acc && ({29'd0, c} < NA)) begin
      exp_q.push_back(agent_fn(int'(c), a));
      exp_starts++;
      exp_results++;
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input string tag);
    int n;
    for (n = 0; n < 300; n++) begin
      @(negedge clk);
      if (state_dbg == s) break;
      tick();
    end
    check(tag, (n < 300), 1);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    for (n = 0; n < 500; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && state_dbg == 3'd0) break;
      tick();
    end
    check(tag, (n < 500), 1);
  endtask

  logic [31:0] held;
`ifdef CMD_DISPATCHER_PERF_EN
  logic [31:0] perf0;
`endif

  initial begin
    // reset state
    repeat (3) tick();
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_res_valid", res_valid, 0);
    check("rst_res", res, 0);
    check("rst_cmd_error", cmd_error, 0);
    check("rst_agent_start", agent_start, 0);
    check("rst_agent_arg0", agent_arg0, 0);
    check("rst_state", state_dbg, 0);
    check("rst_arena_wr", arena_columns_write, 0);
`ifdef CMD_DISPATCHER_PERF_EN
    check("rst_perf", perf, 0);
`endif
    reset = 1'b0;
    tick();

    // single command, start latency, result stall with another command queued
    busy_len[2] = 5;
    busy_len[1] = 2;
    send(3'd2, 32'h0000_0305);
    @(negedge clk);
    check("t1_no_start_n1", agent_start, 0);
    tick();
    @(negedge clk);
    check("t1_start_n2", agent_start, 4'b0100);
    check("t1_arg0", agent_arg0, 32'h0000_0305);
    check("t1_state_start", state_dbg, 1);
    tick();
    wait_state(3'd4, "t1_wait_result");
    check("t1_res", res, agent_fn(2, 32'h0000_0305));
    check("t1_res_valid", res_valid, 1);
    held = res;
`ifdef CMD_DISPATCHER_PERF_EN
    perf0 = perf;
`endif
    tick();
    send(3'd1, 32'hABCD_0001);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("t1_stall_res", res, held);
      check("t1_stall_valid", res_valid, 1);
      check("t1_stall_no_start", agent_start, 0);
`ifdef CMD_DISPATCHER_PERF_EN
      check("t1_stall_perf", perf, perf0 + 32'(k + 2));
`endif
      tick();
    end
    res_ready = 1'b1;
    wait_drain("t1_drain");
    tick();

    // back-to-back burst against a busy agent
    busy_len[1] = 8;
    busy_len[0] = 1;
    for (int j = 0; j < 5; j++) send(3'd1, 32'h1000_0000 + 32'(j));
    @(negedge clk);
    check("t2_full", cmd_ready, 0);
    tick();
    send(3'd0, 32'h0000_00F0);
    wait_drain("t2_drain");
    tick();

    // out-of-range indices
    send(3'd5, 32'h5555_5555);
    @(negedge clk);
    check("t3_err_pulse", cmd_error, 1);
    check("t3_err_no_start", agent_start, 0);
    tick();
    @(negedge clk);
    check("t3_err_one_cycle", cmd_error, 0);
    check("t3_err_idle", state_dbg, 0);
    tick();
    send(3'd4, 32'h4444_4444);
    send(3'd7, 32'h7777_7777);
    send(3'd0, 32'h0000_0A0A);
    wait_drain("t3_drain");

    // arena routing
    check("t4_idle_wr", arena_columns_write, 0);
    check("t4_idle_row", arena_row_select, 0);
    check("t4_idle_cols", arena_columns_new, 0);
    tick();
    for (int i = 0; i < NA; i++) begin
      agent_row_select[i*8 +: 8]   = 8'h20 + 8'(i);
      agent_columns_new[i*10 +: 10] = 10'h200 + 10'(i);
    end
    agent_row_select[3*8 +: 8]    = 8'd7;
    agent_columns_new[3*10 +: 10] = 10'h155;
    agent_columns_write = 4'b1001;
    busy_len[3] = 6;
    send(3'd3, 32'h0000_0033);
    wait_state(3'd3, "t4_wait_state");
    check("t4_row", arena_row_select, 7);
    check("t4_cols", arena_columns_new, 10'h155);
    check("t4_wr", arena_columns_write, 1);
    tick();
    wait_drain("t4_drain");
    check("t4_after_wr", arena_columns_write, 0);
    check("t4_after_row", arena_row_select, 0);
    tick();

    // reset in WAIT with two queued commands
    busy_len[2] = 20;
    send(3'd2, 32'h0000_0222);
    send(3'd0, 32'h0000_0100);
    send(3'd1, 32'h0000_0101);
    wait_state(3'd3, "t5_wait_state");
    tick();
    reset = 1'b1;
    exp_q.delete();
    exp_starts -= 2;
    exp_results -= 3;
    tick();
    @(negedge clk);
    check("t5_state", state_dbg, 0);
    check("t5_cmd_ready", cmd_ready, 1);
    check("t5_res_valid", res_valid, 0);
    check("t5_agent_arg0", agent_arg0, 0);
`ifdef CMD_DISPATCHER_PERF_EN
    check("t5_perf", perf, 0);
`endif
    reset = 1'b0;
    tick();
    repeat (25) tick();
    @(negedge clk);
    check("t5_stay_idle", state_dbg, 0);
    tick();
    busy_len[2] = 1;
    send(3'd2, 32'h0000_1234);
    wait_drain("t5_drain");

    // totals
    check("err_pulses", err_pulses, 3);
    check("start_count", start_cnt, exp_starts);
    check("result_count", res_cnt, exp_results);
    check("sb_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
